// File: rtl/mole_round_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : mole_round_scheduler
// Purpose : whack-a-mole game sequencer (quiet gap, lit show window, scoring)
// Revision: 1.0  initial release
// ============================================================================
module mole_round_scheduler #(
    parameter int         NUM_MOLES  = 4,
    parameter int         GAP_TICKS  = 250,
    parameter int         SHOW_TICKS = 500,
    parameter int         NUM_ROUNDS = 20,
    parameter int         TICK_W     = 10,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic                 start,
    input  logic [NUM_MOLES-1:0] hit,
    output logic [NUM_MOLES-1:0] mole_oh,
    output logic                 busy,
    output logic [7:0]           score,
    output logic [7:0]           misses,
    output logic                 round_done,
    output logic                 game_done
);

    localparam int                c_IDX_W      = $clog2(NUM_MOLES);
    localparam logic [TICK_W-1:0] c_GAP_LOAD   = TICK_W'(GAP_TICKS - 1);
    localparam logic [TICK_W-1:0] c_SHOW_LOAD  = TICK_W'(SHOW_TICKS - 1);
    localparam logic [7:0]        c_LAST_ROUND = 8'(NUM_ROUNDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GAP  = 2'd1,
        S_SHOW = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                state_q,      state_d;
    logic [TICK_W-1:0]     tick_cnt_q,   tick_cnt_d;
    logic [7:0]            round_q,      round_d;
    logic [7:0]            lfsr_q,       lfsr_d;
    logic [NUM_MOLES-1:0]  mole_oh_q,    mole_oh_d;
    logic                  busy_q,       busy_d;
    logic [7:0]            score_q,      score_d;
    logic [7:0]            misses_q,     misses_d;
    logic                  round_done_q, round_done_d;
    logic                  game_done_q,  game_done_d;
    logic                  round_end;

    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        round_d      = round_q;
        mole_oh_d    = mole_oh_q;
        busy_d       = busy_q;
        score_d      = score_q;
        misses_d     = misses_q;
        round_done_d = 1'b0;
        game_done_d  = 1'b0;
        round_end    = 1'b0;
        // Free-running x^8+x^6+x^5+x^4+1 so the mole sequence depends on start timing
        lfsr_d       = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_GAP;
                    busy_d     = 1'b1;
                    score_d    = 8'd0;
                    misses_d   = 8'd0;
                    round_d    = 8'd0;
                    tick_cnt_d = c_GAP_LOAD;
                end
            end
            S_GAP: begin
                if (tick) begin
                    if (tick_cnt_q == '0) begin
                        state_d    = S_SHOW;
                        tick_cnt_d = c_SHOW_LOAD;
                        mole_oh_d  = NUM_MOLES'(1) << lfsr_q[c_IDX_W-1:0];
                    end else begin
                        tick_cnt_d = tick_cnt_q - 1'b1;
                    end
                end
            end
            S_SHOW: begin
                // A correct hit outranks a timeout tick arriving in the same cycle
                if (|(hit & mole_oh_q)) begin
                    round_end = 1'b1;
                    score_d   = (score_q != 8'hFF) ? score_q + 8'd1 : score_q;
                end else if (tick) begin
                    if (tick_cnt_q == '0) begin
                        round_end = 1'b1;
                        misses_d  = (misses_q != 8'hFF) ? misses_q + 8'd1 : misses_q;
                    end else begin
                        tick_cnt_d = tick_cnt_q - 1'b1;
                    end
                end
                if (round_end) begin
                    mole_oh_d    = '0;
                    round_done_d = 1'b1;
                    round_d      = round_q + 8'd1;
                    if (round_q + 8'd1 == c_LAST_ROUND) begin
                        state_d     = S_DONE;
                        busy_d      = 1'b0;
                        game_done_d = 1'b1;
                    end else begin
                        state_d    = S_GAP;
                        tick_cnt_d = c_GAP_LOAD;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            tick_cnt_q   <= '0;
            round_q      <= 8'd0;
            lfsr_q       <= LFSR_SEED;
            mole_oh_q    <= '0;
            busy_q       <= 1'b0;
            score_q      <= 8'd0;
            misses_q     <= 8'd0;
            round_done_q <= 1'b0;
            game_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            round_q      <= round_d;
            lfsr_q       <= lfsr_d;
            mole_oh_q    <= mole_oh_d;
            busy_q       <= busy_d;
            score_q      <= score_d;
            misses_q     <= misses_d;
            round_done_q <= round_done_d;
            game_done_q  <= game_done_d;
        end
    end

    assign mole_oh    = mole_oh_q;
    assign busy       = busy_q;
    assign score      = score_q;
    assign misses     = misses_q;
    assign round_done = round_done_q;
    assign game_done  = game_done_q;

endmodule
`default_nettype wire

// File: tb/tb_mole_round_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_mole_round_scheduler
// Purpose : randomized scoreboard bench for mole_round_scheduler
// Revision: 1.0  initial release
// ============================================================================
module tb_mole_round_scheduler;

    localparam int         c_NM   = 4;
    localparam int         c_GT   = 2;
    localparam int         c_ST   = 4;
    localparam int         c_NR   = 3;
    localparam int         c_TW   = 3;
    localparam logic [7:0] c_SEED = 8'hA5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            tick = 1'b0;
    logic            start = 1'b0;
    logic [c_NM-1:0] hit = '0;
    logic [c_NM-1:0] mole_oh;
    logic            busy;
    logic [7:0]      score;
    logic [7:0]      misses;
    logic            round_done;
    logic            game_done;

    mole_round_scheduler #(
        .NUM_MOLES (c_NM),
        .GAP_TICKS (c_GT),
        .SHOW_TICKS(c_ST),
        .NUM_ROUNDS(c_NR),
        .TICK_W    (c_TW),
        .LFSR_SEED (c_SEED)
    ) dut (
        .clk_in    (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .start     (start),
        .hit       (hit),
        .mole_oh   (mole_oh),
        .busy      (busy),
        .score     (score),
        .misses    (misses),
        .round_done(round_done),
        .game_done (game_done)
    );

    always #5 clk = ~clk;

    typedef enum {M_IDLE, M_GAP, M_SHOW, M_DONE} mphase_t;
    typedef struct {
        int cyc;
        int score;
        int misses;
        int game;
    } rec_t;

    mphase_t    m_phase = M_IDLE;
    int         m_gap_seen, m_show_seen, m_rounds, m_score, m_misses, m_mole;
    logic [7:0] m_lfsr = c_SEED;
    int         cyc = 0;
    bit         m_valid = 1'b0;
    rec_t       rq[$];

    int vectors = 0;
    int errors  = 0;
    int tick_wait = 0;

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic void check(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endfunction

    function automatic void end_round(input bit was_hit);
        rec_t r;
        if (was_hit) m_score  = (m_score  < 255) ? m_score + 1  : 255;
        else         m_misses = (m_misses < 255) ? m_misses + 1 : 255;
        m_rounds++;
        r.cyc = cyc; r.score = m_score; r.misses = m_misses;
        r.game = (m_rounds == c_NR) ? 1 : 0;
        rq.push_back(r);
        if (m_rounds == c_NR) m_phase = M_DONE;
        else begin
            m_phase    = M_GAP;
            m_gap_seen = 0;
        end
    endfunction

    // Reference model: phase plus up-counts of ticks seen, evaluated at each edge
    initial begin
        logic [7:0] cur;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                m_phase = M_IDLE; m_rounds = 0; m_score = 0; m_misses = 0;
                m_gap_seen = 0; m_show_seen = 0; m_mole = 0;
                m_lfsr = c_SEED; m_valid = 1'b1;
            end else begin
                cur    = m_lfsr;
                m_lfsr = lfsr_step(m_lfsr);
                case (m_phase)
                    M_IDLE, M_DONE: if (start) begin
                        m_phase = M_GAP; m_gap_seen = 0;
                        m_rounds = 0; m_score = 0; m_misses = 0;
                    end
                    M_GAP: if (tick) begin
                        m_gap_seen++;
                        if (m_gap_seen == c_GT) begin
                            m_phase = M_SHOW; m_show_seen = 0;
                            m_mole = int'(cur[1:0]);
                        end
                    end
                    M_SHOW: begin
                        if ((hit & (4'b0001 << m_mole)) != 4'b0000) end_round(1'b1);
                        else if (tick) begin
                            m_show_seen++;
                            if (m_show_seen == c_ST) end_round(1'b0);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Monitor: level outputs every cycle, round events popped from the scoreboard
    initial begin
        rec_t r;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                check("busy", int'(busy), (m_phase == M_GAP || m_phase == M_SHOW) ? 1 : 0);
                check("mole_oh", int'(mole_oh), (m_phase == M_SHOW) ? int'(4'b0001 << m_mole) : 0);
                check("score", int'(score), m_score);
                check("misses", int'(misses), m_misses);
                if (round_done) begin
                    if (rq.size() == 0) check("round_done_unexpected", 1, 0);
                    else begin
                        r = rq.pop_front();
                        check("round_done_cycle", cyc, r.cyc);
                        check("round_score", int'(score), r.score);
                        check("round_misses", int'(misses), r.misses);
                        check("game_done", int'(game_done), r.game);
                    end
                end else begin
                    check("game_done_stray", int'(game_done), 0);
                    if (rq.size() != 0) begin
                        r = rq.pop_front();
                        check("round_done_missing", 0, 1);
                    end
                end
            end
        end
    end

    // mode 0: no hits, 1: random hits, 2: hit on timeout tick, 3: wrong then correct hit
    task automatic drive_cycle(input int mode, input bit allow_start);
        if (tick_wait == 0) begin
            tick = 1'b1;
            tick_wait = $urandom_range(0, 5);
        end else begin
            tick = 1'b0;
            tick_wait--;
        end
        hit = '0;
        case (mode)
            1: if ($urandom_range(0, 7) == 0) hit = 4'($urandom_range(1, 15));
            2: if (m_phase == M_SHOW && m_show_seen == c_ST - 1 && tick)
                   hit = 4'b0001 << m_mole;
            3: begin
                if (m_phase == M_GAP && $urandom_range(0, 3) == 0) hit = 4'($urandom_range(1, 15));
                else if (m_phase == M_SHOW && m_show_seen == 0)
                    hit = 4'b0001 << ((m_mole + 1) % c_NM);
                else if (m_phase == M_SHOW && m_show_seen == 1)
                    hit = 4'b0001 << m_mole;
            end
            default: ;
        endcase
        start = allow_start && (m_phase == M_GAP || m_phase == M_SHOW)
                && ($urandom_range(0, 15) == 0);
        @(negedge clk);
    endtask

    task automatic run_game(input int mode);
        int hold;
        hold = $urandom_range(1, 3);
        for (int i = 0; i < hold; i++) begin
            tick = ($urandom_range(0, 1) == 1);
            hit  = '0;
            start = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
        for (int i = 0; i < 3000 && m_phase != M_DONE; i++) drive_cycle(mode, 1'b1);
        check("game_complete", (m_phase == M_DONE) ? 1 : 0, 1);
        for (int i = 0; i < 4; i++) drive_cycle(0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) drive_cycle(1, 1'b0);

        for (int g = 0; g < 12; g++) run_game(g % 4);

        // Reset in the middle of a show window, then a fresh game
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 500 && m_phase != M_SHOW; i++) drive_cycle(0, 1'b0);
        check("reached_show", (m_phase == M_SHOW) ? 1 : 0, 1);
        rst_n = 1'b0;
        tick = 1'b0;
        hit = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) drive_cycle(1, 1'b0);
        run_game(1);
        run_game(2);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", rq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mole_round_scheduler.md
# mole_round_scheduler

Game-round sequencer for the whack-a-mole datapath. Consumes the single-cycle timebase pulse produced by the clock divider in pulse mode, and schedules a fixed number of rounds. Each round is a quiet gap followed by a show window with one pseudo-randomly chosen mole lit. The block scores player hits against the lit mole and sits between the timebase, the debounced button inputs, and the LED/score display logic.

## Interface
- NUM_MOLES, 4: mole count; power of 2, range 2..8.
- GAP_TICKS, 250: ticks with no mole lit before each show window; ≥1.
- SHOW_TICKS, 500: ticks a mole stays lit; ≥1.
- NUM_ROUNDS, 20: rounds per game; 1..255.
- TICK_W, 10: tick-counter width; must hold max(GAP_TICKS, SHOW_TICKS)-1.
- LFSR_SEED, 8'hA5: LFSR reset value; nonzero.
- clk_in  input  1  system clock; all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- tick  input  1  one-clk_in-cycle timebase pulse from the clock divider in pulse mode.
- start  input  1  level or pulse; sampled only in IDLE and DONE.
- hit  input  NUM_MOLES  debounced single-cycle button pulses, one bit per mole.
- mole_oh  output  NUM_MOLES  one-hot lit mole; all zero outside SHOW.
- busy  output  1  high in GAP or SHOW.
- score  output  8  hits this game; saturates at 255.
- misses  output  8  timed-out rounds this game; saturates at 255.
- round_done  output  1  one-cycle pulse at the end of each round.
- game_done  output  1  one-cycle pulse on entry to DONE.

## Operation
- States: IDLE, GAP, SHOW, DONE. All outputs are registered.
- Reset (rst_n=0 at an edge), including mid-game:
  - state=IDLE; mole_oh=0, busy=0, score=0, misses=0, round_done=0, game_done=0.
  - Tick counter=0, round counter=0, LFSR=LFSR_SEED.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Advances every clk_in cycle when not in reset, so the mole pattern depends on start timing. Mole index = LFSR[log2(NUM_MOLES)-1:0], sampled at the GAP→SHOW transition. Repeating the same mole in consecutive rounds is legal.
- IDLE: on start=1, go to GAP.
  - Clear score, misses and round counter.
  - Load tick counter with GAP_TICKS-1.
- GAP: on each tick, if the counter is 0, go to SHOW; otherwise decrement.
  - On entry to SHOW, load SHOW_TICKS-1 and set mole_oh to the one-hot of the sampled index.
  - GAP therefore lasts exactly GAP_TICKS ticks. Hits in GAP are ignored.
- SHOW, correct hit: `(hit & mole_oh) != 0` ends the round.
  - score+1 (saturating), mole_oh cleared, round_done pulse.
- SHOW, timeout: on a tick with the counter at 0 and no correct hit, end the round.
  - misses+1 (saturating), mole_oh cleared, round_done pulse.
- SHOW, wrong hit: hit bits not matching mole_oh are ignored.
- SHOW, otherwise: decrement the counter on each tick.
- Round end: increment the round counter.
  - If it equals NUM_ROUNDS, go to DONE with game_done pulsed.
  - Otherwise go to GAP with GAP_TICKS-1 loaded.
- DONE: score and misses hold. On start=1, clear them and go to GAP, same as from IDLE.
- start while busy is ignored.
- Invariant: score + misses = completed rounds.

## Timing
- All transitions happen on the clk_in edge where the qualifying input is sampled. Outputs are valid the following cycle.
- Correct hit at edge t: score, mole_oh=0 and round_done are visible after t. The next mole lights exactly GAP_TICKS ticks later.
- Hit and timeout tick in the same cycle: the hit wins. Score increments, misses does not.
- tick and start in the same cycle in IDLE: the tick is not counted. GAP counting starts with the next tick.
- round_done and game_done rise together on the final round's end cycle, each for exactly one cycle.
- tick held high for several cycles counts once per cycle. Callers must deliver single-cycle pulses.

## Test plan
- Reset/idle: hold rst_n=0 for 3 cycles, then release with no start → all outputs 0, state IDLE, mole_oh=0 for 100 cycles.
- Full miss game (GAP_TICKS=2, SHOW_TICKS=4, NUM_ROUNDS=3, tick every 5 clk_in, no hits):
  - Each mole is lit for exactly 4 ticks after exactly 2 quiet ticks.
  - misses=3, score=0; 3 round_done pulses; game_done coincides with the third.
- Correct hit: press the lit mole on its second show tick → score=1, misses=0, mole_oh=0 next cycle, round_done one cycle.
- Wrong and early hits:
  - Hit a non-lit mole in SHOW → no score change.
  - Hit any mole in GAP → no effect.
- Hit on the timeout tick: hit coincides with the final SHOW tick → score+1, misses unchanged.
- Mid-game reset and restart:
  - rst_n=0 during SHOW → mole_oh=0, score=0 after the edge.
  - After a completed game, assert start in DONE → score and misses cleared, new game runs.
